// File: rtl/soc_estimator_mc.sv
// soc_estimator_mc: multi-channel hybrid state-of-charge estimator.
// One ESR/OCV/coulomb datapath is shared by all channels and swept once per sample tick.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   voltage_in  packed unsigned cell voltages (mV), channel c at [c*VW +: VW]
//   current_in  packed signed cell currents (mA, +ve = charge), channel c at [c*IW +: IW]
//   soc_out     packed SoC in percent, channel c at [c*8 +: 8]
//   v_mode      per channel: 1 = last SoC from voltage, 0 = coulomb counted
//   soc_valid   one-cycle pulse after a full sweep
//   busy        high while a sweep is in progress
module soc_estimator_mc #(
  parameter int N_CH        = 4,
  parameter int VW          = 16,
  parameter int IW          = 16,
  parameter int TICK_CYCLES = 50000,
  parameter int V_MIN       = 3000,
  parameter int V_MAX       = 4200,
  parameter int ESR_MOHM    = 100,
  parameter int I_THRESH    = 50,
  parameter int REST_TICKS  = 1000,
  parameter int Q_FULL      = 3600000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH*VW-1:0] voltage_in,
  input  logic [N_CH*IW-1:0] current_in,
  output logic [N_CH*8-1:0]  soc_out,
  output logic [N_CH-1:0]    v_mode,
  output logic               soc_valid,
  output logic               busy
);

  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CW  = VW + IW + 11;
  localparam int QW  = $clog2(Q_FULL) + ((IW > 6) ? IW : 6) + 2;
  localparam int RW  = $clog2(REST_TICKS + 1);
  localparam int SW  = VW + 8;

  localparam logic signed [CW-1:0] ESR_C  = CW'(ESR_MOHM);
  localparam logic signed [CW-1:0] K1000  = CW'(1000);
  localparam logic signed [CW-1:0] VTOP_C = CW'((1 << VW) - 1);
  localparam logic [VW-1:0]        VMIN_C = VW'(V_MIN);
  localparam logic [VW-1:0]        VMAX_C = VW'(V_MAX);
  localparam logic [SW-1:0]        VSPAN  = SW'(V_MAX - V_MIN);
  localparam logic signed [QW-1:0] QFULL_Q = QW'(Q_FULL);
  localparam logic signed [QW-1:0] H100_Q  = QW'(100);
  localparam logic [RW-1:0]        REST_C  = RW'(REST_TICKS);
  localparam logic [PW-1:0]        PLAST   = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COMP, UPD, DONE} state_t;

  state_t           state, state_nx;
  logic [CHW-1:0]   ch, ch_nx;
  logic [PW-1:0]    presc;
  logic             tick;

  logic [VW-1:0]          v_comp;
  logic signed [IW-1:0]   i_reg;
  logic signed [QW-1:0]   q_accum [N_CH];
  logic [RW-1:0]          rest_cnt [N_CH];
  logic [N_CH-1:0]        init_done;

  // Sample tick prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                presc <= '0;
    else if (presc == PLAST) presc <= '0;
    else                    presc <= presc + 1'b1;
  end

  assign tick = (presc == PLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= state_nx;
      ch    <= ch_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ch_nx     = ch;
    soc_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (tick) begin
          state_nx = COMP;
          ch_nx    = '0;
        end
      end
      COMP: state_nx = UPD;
      UPD: begin
        if (ch == CHW'(N_CH - 1)) state_nx = DONE;
        else begin
          state_nx = COMP;
          ch_nx    = ch + 1'b1;
        end
      end
      DONE: begin
        soc_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // COMP stage: channel select and ESR compensation
  logic [VW-1:0]        v_sel;
  logic signed [IW-1:0] i_sel;
  logic signed [CW-1:0] v_ext, i_ext, drop, vc_full;
  logic [VW-1:0]        vc_clamped;

  always_comb begin
    v_sel   = voltage_in[ch*VW +: VW];
    i_sel   = current_in[ch*IW +: IW];
    v_ext   = {{(CW-VW){1'b0}}, v_sel};
    i_ext   = CW'(i_sel);
    drop    = (i_ext * ESR_C) / K1000;
    vc_full = v_ext - drop;
    if (vc_full < 0)           vc_clamped = '0;
    else if (vc_full > VTOP_C) vc_clamped = '1;
    else                       vc_clamped = vc_full[VW-1:0];
  end

  // UPD stage: OCV lookup, rest qualification, charge integration
  logic [7:0]           soc_v, soc_c;
  logic signed [QW-1:0] soc_v_q, q_from_v, q_sum, q_clamp;
  logic signed [31:0]   i_w;
  logic                 is_rest, recal;
  logic [RW-1:0]        rest_nx;

  always_comb begin
    if (v_comp <= VMIN_C)      soc_v = 8'd0;
    else if (v_comp >= VMAX_C) soc_v = 8'd100;
    else                       soc_v = 8'((SW'(v_comp - VMIN_C) * SW'(100)) / VSPAN);

    soc_v_q  = QW'(soc_v);
    q_from_v = (soc_v_q * QFULL_Q) / H100_Q;

    q_sum = q_accum[ch] + QW'(i_reg);
    if (q_sum < 0)            q_clamp = '0;
    else if (q_sum > QFULL_Q) q_clamp = QFULL_Q;
    else                      q_clamp = q_sum;
    soc_c = 8'((q_clamp * H100_Q) / QFULL_Q);

    i_w     = 32'(i_reg);
    is_rest = (i_w <= I_THRESH) && (i_w >= -I_THRESH);
    if (!is_rest)                  rest_nx = '0;
    else if (rest_cnt[ch] == REST_C) rest_nx = REST_C;
    else                           rest_nx = rest_cnt[ch] + 1'b1;
    recal = (rest_nx == REST_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_comp    <= '0;
      i_reg     <= '0;
      soc_out   <= '0;
      v_mode    <= '1;
      init_done <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        q_accum[c]  <= '0;
        rest_cnt[c] <= '0;
      end
    end else begin
      case (state)
        COMP: begin
          v_comp <= vc_clamped;
          i_reg  <= i_sel;
        end
        UPD: begin
          rest_cnt[ch] <= rest_nx;
          if (!init_done[ch] || recal) begin
            q_accum[ch]        <= q_from_v;
            soc_out[ch*8 +: 8] <= soc_v;
            v_mode[ch]         <= 1'b1;
            init_done[ch]      <= 1'b1;
          end else begin
            q_accum[ch]        <= q_clamp;
            soc_out[ch*8 +: 8] <= soc_c;
            v_mode[ch]         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_estimator_mc.sv
// tb_soc_estimator_mc: directed scoreboard bench for soc_estimator_mc (2 channels).
module tb_soc_estimator_mc;

  localparam int N_CH = 2;
  localparam int VW   = 16;
  localparam int IW   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_CH*VW-1:0] voltage_in;
  logic [N_CH*IW-1:0] current_in;
  logic [N_CH*8-1:0]  soc_out;
  logic [N_CH-1:0]    v_mode;
  logic               soc_valid;
  logic               busy;

  soc_estimator_mc #(
    .N_CH(N_CH), .VW(VW), .IW(IW), .TICK_CYCLES(20), .V_MIN(1000), .V_MAX(2000),
    .ESR_MOHM(1000), .I_THRESH(5), .REST_TICKS(4), .Q_FULL(10000)
  ) dut (
    .clk(clk), .rst(rst), .voltage_in(voltage_in), .current_in(current_in),
    .soc_out(soc_out), .v_mode(v_mode), .soc_valid(soc_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] s0;
    logic [7:0] s1;
    logic [1:0] vm;
    logic [7:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s (vec %0d): got %0d, expected %0d", name, id, act, req);
    end
  endtask

  // Monitor: pops one expectation per soc_valid pulse
  always @(negedge clk) begin
    if (rst) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      else      busy_cnt = 0;
      if (soc_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_soc_valid: got pulse, expected none at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("soc0", e.id, soc_out[7:0], e.s0);
          check("soc1", e.id, soc_out[15:8], e.s1);
          check("v_mode", e.id, v_mode, e.vm);
          check("latency", e.id, busy_cnt, 2*N_CH+1);
        end
      end
    end
  end

  int vec_id = 0;

  task automatic sweep(input int v0, input int v1, input int i0, input int i1,
                       input int s0, input int s1, input logic [1:0] vm);
    exp_t e;
    int n;
    @(negedge clk);
    voltage_in = {16'(v1), 16'(v0)};
    current_in = {16'(i1), 16'(i0)};
    e.s0 = 8'(s0); e.s1 = 8'(s1); e.vm = vm; e.id = 8'(vec_id);
    exp_q.push_back(e);
    n = 0;
    while (!soc_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!soc_valid) begin
      checks++;
      fails++;
      $display("FAIL sweep_timeout (vec %0d): got no soc_valid, expected one within 60 cycles", vec_id);
    end
    vec_id++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    voltage_in = {16'd1500, 16'd1500};
    current_in = '0;
    repeat (3) @(negedge clk);
    check("reset_soc", 0, soc_out, 0);
    check("reset_vmode", 0, v_mode, 3);
    check("reset_valid", 0, soc_valid, 0);
    check("reset_busy", 0, busy, 0);
    rst = 1'b0;

    // T1: first sweep initialises from voltage
    sweep(1500, 1500, 0, 0, 50, 50, 2'b11);

    // T2: ch0 counts +100 per tick; ch1 at rest recalibrates once rest_cnt hits 4
    for (int k = 1; k <= 10; k++)
      sweep(1500, 1500, 100, 0, 50 + k, 50, (k >= 3) ? 2'b10 : 2'b00);

    // T3: ch0 rest, recalibration on the 4th rest tick
    for (int k = 1; k <= 4; k++)
      sweep(1800, 1500, 0, 0, (k < 4) ? 60 : 80, 50, (k < 4) ? 2'b10 : 2'b11);

    // T4: saturation at Q_FULL and at zero
    sweep(1800, 1500, 1500, 0, 95, 50, 2'b10);
    sweep(1800, 1500, 1000, 0, 100, 50, 2'b10);
    sweep(1800, 1500, 1000, 0, 100, 50, 2'b10);
    sweep(1800, 1500, -3000, 0, 70, 50, 2'b10);
    sweep(1800, 1500, -3000, 0, 40, 50, 2'b10);
    sweep(1800, 1500, -3000, 0, 10, 50, 2'b10);
    sweep(1800, 1500, -3000, 0, 0, 50, 2'b10);
    sweep(1800, 1500, -3000, 0, 0, 50, 2'b10);
    sweep(1800, 1500, 100, 0, 1, 50, 2'b10);

    // T5: forced re-init, ESR compensation and over-range voltage
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sweep(2010, 1500, 0, -3, 100, 50, 2'b11);
    sweep(2010, 2010, 0, 0, 100, 50, 2'b00);
    sweep(2010, 2010, 0, 0, 100, 50, 2'b00);
    sweep(2010, 2010, 0, 0, 100, 100, 2'b11);

    // T6: reset during UPD of ch1 aborts the sweep
    @(negedge clk);
    voltage_in = {16'd1999, 16'd1000};
    current_in = {16'd0, 16'd10};
    begin
      int n;
      n = 0;
      while (!busy && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("t6_sweep_start", 6, busy, 1);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_soc", 6, soc_out, 0);
    check("t6_rst_vmode", 6, v_mode, 3);
    check("t6_rst_busy", 6, busy, 0);
    check("t6_rst_valid", 6, soc_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sweep(1000, 1999, 10, 0, 0, 99, 2'b11);
    sweep(1000, 1999, 200, 0, 2, 99, 2'b00);

    repeat (5) @(negedge clk);
    check("pending_expectations", 0, exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
